// File: rtl/swc_prio_scheduler.sv
// Strict-priority descriptor scheduler for the switch core.
// Eight (by default) circular descriptor FIFOs, one per priority. The
// highest-index non-empty queue feeds a two-state output register stage.
//
// Handshakes:
//   write side: wr_ack_o = wr_valid_i & ~full[prio]. The descriptor is pushed
//     on the edge where wr_ack_o is high. The writer holds its descriptor
//     until acked.
//   read side: the descriptor on rd_* is valid while rd_valid_o=1. It is
//     consumed on an edge where rd_valid_o & rd_ready_i. The outputs stay
//     stable while rd_valid_o=1 and rd_ready_i=0.
module swc_prio_scheduler #(
  parameter int g_num_prio           = 8,
  parameter int g_queue_depth        = 16,
  parameter int g_page_addr_width    = 10,
  parameter int g_max_pck_size_width = 14
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,

  input  logic                            wr_valid_i,
  input  logic [g_page_addr_width-1:0]    wr_pageaddr_i,
  input  logic [2:0]                      wr_prio_i,
  input  logic [g_max_pck_size_width-1:0] wr_pck_size_i,
  output logic                            wr_ack_o,

  output logic                            rd_valid_o,
  input  logic                            rd_ready_i,
  output logic [g_page_addr_width-1:0]    rd_pageaddr_o,
  output logic [g_max_pck_size_width-1:0] rd_pck_size_o,
  output logic [2:0]                      rd_prio_o,

  output logic [g_num_prio-1:0]           queue_empty_o,
  output logic [g_num_prio-1:0]           queue_full_o,
  output logic                            idle_o,

  // Output-stage FSM state, for checkers (0 = IDLE, 1 = VALID).
  output logic                            dbg_state_o
);

  localparam int PTR_W = $clog2(g_queue_depth);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(g_queue_depth);
  localparam logic [2:0]       LAST_PRIO = 3'(g_num_prio - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // ---------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------
  logic [2:0]            wr_prio_c;
  logic                  wr_ack;
  logic [g_num_prio-1:0] empty_q;
  logic [g_num_prio-1:0] full_q;

  // Out-of-range priorities are folded onto the top queue.
  assign wr_prio_c = ({29'd0, wr_prio_i} >= 32'(g_num_prio)) ? LAST_PRIO : wr_prio_i;

  // Acceptance uses the registered full flag, so a pop on the same edge
  // cannot make room for a push into a full queue.
  assign wr_ack   = wr_valid_i && !full_q[wr_prio_c];
  assign wr_ack_o = wr_ack;

  // ---------------------------------------------------------------------
  // Winner selection and output-stage state
  // ---------------------------------------------------------------------
  logic [0:0] state_q;
  logic       win_found;
  logic [2:0] win_idx;
  logic       load;

  logic [g_page_addr_width-1:0]    head_page [g_num_prio];
  logic [g_max_pck_size_width-1:0] head_size [g_num_prio];

  // Strict priority over the registered empty flags: the highest index wins
  // because later loop iterations overwrite earlier ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int q = 0; q < g_num_prio; q++) begin
      if (!empty_q[q]) begin
        win_found = 1'b1;
        win_idx   = 3'(q);
      end
    end
  end

  // A new head is loaded (and popped) when the output register is free or
  // is being emptied on this edge. Priority is only evaluated here, so a
  // presented descriptor is never pre-empted.
  assign load = win_found && ((state_q == ST_IDLE) || rd_ready_i);

  // ---------------------------------------------------------------------
  // Per-priority circular FIFOs
  // ---------------------------------------------------------------------
  for (genvar q = 0; q < g_num_prio; q++) begin : g_queue
    logic [g_page_addr_width-1:0]    page_mem [g_queue_depth];
    logic [g_max_pck_size_width-1:0] size_mem [g_queue_depth];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             empty_r;
    logic             full_r;
    logic             push;
    logic             pop;

    assign push = wr_ack && (wr_prio_c == 3'(q));
    assign pop  = load && (win_idx == 3'(q));

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
      count_nxt = count_q;
      if (push && !pop) begin
        count_nxt = count_q + 1'b1;
      end else if (!push && pop) begin
        count_nxt = count_q - 1'b1;
      end
    end

    // Pointers, occupancy and registered flags; pointers wrap naturally
    // because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        empty_r  <= 1'b1;
        full_r   <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_nxt;
        empty_r <= (count_nxt == '0);
        full_r  <= (count_nxt == DEPTH_CNT);
      end
    end

    // Descriptor storage; contents need no reset because the flags guard it.
    always_ff @(posedge clk_i) begin
      if (push) begin
        page_mem[wr_ptr_q] <= wr_pageaddr_i;
        size_mem[wr_ptr_q] <= wr_pck_size_i;
      end
    end

    assign head_page[q] = page_mem[rd_ptr_q];
    assign head_size[q] = size_mem[rd_ptr_q];
    assign empty_q[q]   = empty_r;
    assign full_q[q]    = full_r;
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic [g_page_addr_width-1:0]    rd_page_q;
  logic [g_max_pck_size_width-1:0] rd_size_q;
  logic [2:0]                      rd_prio_q;

  // IDLE/VALID sequencing: go VALID on a load, drop to IDLE when the
  // presented descriptor is taken and nothing is waiting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (rd_ready_i && !win_found) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output data register: captures the winning head on a load, otherwise
  // holds (including after returning to IDLE).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_page_q <= '0;
      rd_size_q <= '0;
      rd_prio_q <= '0;
    end else if (load) begin
      rd_page_q <= head_page[win_idx];
      rd_size_q <= head_size[win_idx];
      rd_prio_q <= win_idx;
    end
  end

  assign rd_valid_o    = (state_q == ST_VALID);
  assign rd_pageaddr_o = rd_page_q;
  assign rd_pck_size_o = rd_size_q;
  assign rd_prio_o     = rd_prio_q;

  assign queue_empty_o = empty_q;
  assign queue_full_o  = full_q;
  assign idle_o        = (&empty_q) && (state_q == ST_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_swc_prio_scheduler.sv
// Directed bench for swc_prio_scheduler: priority order, full handling,
// latency, no pre-emption, push/pop on a full queue and mid-run reset.
module tb_swc_prio_scheduler;

  localparam int NP = 8;
  localparam int QD = 16;
  localparam int PW = 10;
  localparam int SW = 14;
  localparam int W  = 3 + PW + SW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          wr_valid;
  logic [PW-1:0] wr_pageaddr;
  logic [2:0]    wr_prio;
  logic [SW-1:0] wr_pck_size;
  logic          wr_ack;
  logic          rd_valid;
  logic          rd_ready;
  logic [PW-1:0] rd_pageaddr;
  logic [SW-1:0] rd_pck_size;
  logic [2:0]    rd_prio;
  logic [NP-1:0] queue_empty;
  logic [NP-1:0] queue_full;
  logic          idle;
  logic          dbg_state;

  swc_prio_scheduler #(
    .g_num_prio          (NP),
    .g_queue_depth       (QD),
    .g_page_addr_width   (PW),
    .g_max_pck_size_width(SW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .wr_valid_i   (wr_valid),
    .wr_pageaddr_i(wr_pageaddr),
    .wr_prio_i    (wr_prio),
    .wr_pck_size_i(wr_pck_size),
    .wr_ack_o     (wr_ack),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_pageaddr_o(rd_pageaddr),
    .rd_pck_size_o(rd_pck_size),
    .rd_prio_o    (rd_prio),
    .queue_empty_o(queue_empty),
    .queue_full_o (queue_full),
    .idle_o       (idle),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_desc(input logic [2:0] prio, input logic [PW-1:0] page,
                             input logic [SW-1:0] size);
    exp_q.push_back({prio, page, size});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one descriptor and hold it until acked (bounded).
  task automatic write_desc(input logic [PW-1:0] page, input logic [2:0] prio,
                            input logic [SW-1:0] size);
    logic acked;
    acked       = 1'b0;
    wr_valid    = 1'b1;
    wr_pageaddr = page;
    wr_prio     = prio;
    wr_pck_size = size;
    for (int c = 0; c < 20 && !acked; c++) begin
      #1;
      acked = wr_ack;
      step();
    end
    wr_valid = 1'b0;
    if (!acked) check("wr_ack_timeout", 32'd0, 32'd1);
  endtask

  // Take n descriptors back-to-back and compare against the expected queue.
  task automatic drain(input int n);
    logic [W-1:0] e;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_rd_valid", rd_valid, 1);
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("drain_rd_prio", rd_prio, e[W-1 -: 3]);
        check("drain_rd_pageaddr", rd_pageaddr, e[SW+PW-1 -: PW]);
        check("drain_rd_pck_size", rd_pck_size, e[SW-1:0]);
      end
      step();
    end
    rd_ready = 1'b0;
    check("drain_end_rd_valid", rd_valid, 0);
    check("drain_end_idle", idle, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    wr_valid    = 1'b0;
    wr_pageaddr = '0;
    wr_prio     = '0;
    wr_pck_size = '0;
    rd_ready    = 1'b0;

    // Reset and reset-state checks.
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_idle", idle, 1);
    check("rst_empty", queue_empty, 8'hFF);
    check("rst_full", queue_full, 8'h00);
    check("rst_pageaddr", rd_pageaddr, 0);
    check("rst_pck_size", rd_pck_size, 0);
    check("rst_prio", rd_prio, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Priority order: ten prio-7 then ten prio-0, drained with no bubbles.
    for (int i = 0; i < 10; i++) begin
      write_desc(PW'(i), 3'd7, SW'(10));
      expect_desc(3'd7, PW'(i), SW'(10));
    end
    for (int i = 0; i < 10; i++) begin
      write_desc(PW'(i), 3'd0, SW'(20));
      expect_desc(3'd0, PW'(i), SW'(20));
    end
    check("t1_held_prio", rd_prio, 7);
    check("t1_held_page", rd_pageaddr, 0);
    drain(20);

    // Minimum latency with the reader always ready.
    rd_ready    = 1'b1;
    wr_valid    = 1'b1;
    wr_pageaddr = PW'(5);
    wr_prio     = 3'd3;
    wr_pck_size = SW'(64);
    #1 check("t3_ack", wr_ack, 1);
    step();
    wr_valid = 1'b0;
    check("t3_valid_after_push", rd_valid, 0);
    step();
    check("t3_valid", rd_valid, 1);
    check("t3_prio", rd_prio, 3);
    check("t3_page", rd_pageaddr, 5);
    check("t3_size", rd_pck_size, 64);
    step();
    check("t3_valid_one_cycle", rd_valid, 0);
    check("t3_idle", idle, 1);
    check("t3_data_held", rd_pageaddr, 5);
    rd_ready = 1'b0;

    // Full queue: one descriptor presented from prio 5, then 17 writes to prio 2.
    write_desc(PW'(50), 3'd5, SW'(5));
    for (int i = 0; i < 16; i++) begin
      write_desc(PW'(100 + i), 3'd2, SW'(30));
      expect_desc(3'd2, PW'(100 + i), SW'(30));
    end
    expect_desc(3'd2, PW'(116), SW'(30));
    check("t2_full", queue_full, 8'h04);
    check("t2_empty", queue_empty, 8'hFB);
    check("t2_presented_prio", rd_prio, 5);
    check("t2_presented_page", rd_pageaddr, 50);
    wr_valid    = 1'b1;
    wr_pageaddr = PW'(116);
    wr_prio     = 3'd2;
    wr_pck_size = SW'(30);
    #1 check("t2_ack17_refused", wr_ack, 0);
    step();
    check("t2_ack17_still_refused", wr_ack, 0);
    rd_ready = 1'b1;
    #1 check("t2_ack17_refused_on_pop", wr_ack, 0);
    step();
    rd_ready = 1'b0;
    check("t2_full_cleared", queue_full, 8'h00);
    #1 check("t2_ack17_accepted", wr_ack, 1);
    step();
    wr_valid = 1'b0;
    check("t2_full_again", queue_full, 8'h04);
    drain(17);

    // No pre-emption: prio 1 presented, prio 6 arrives later.
    write_desc(PW'(200), 3'd1, SW'(40));
    expect_desc(3'd1, PW'(200), SW'(40));
    step();
    write_desc(PW'(201), 3'd6, SW'(50));
    expect_desc(3'd6, PW'(201), SW'(50));
    step();
    step();
    check("t4_still_prio1", rd_prio, 1);
    drain(2);

    // Push and pop on a full prio-4 queue on the same edge.
    for (int i = 0; i < 17; i++) begin
      write_desc(PW'(300 + i), 3'd4, SW'(70));
      if (i > 0) expect_desc(3'd4, PW'(300 + i), SW'(70));
    end
    expect_desc(3'd4, PW'(317), SW'(70));
    check("t5_full", queue_full, 8'h10);
    check("t5_presented_page", rd_pageaddr, 300);
    wr_valid    = 1'b1;
    wr_pageaddr = PW'(317);
    wr_prio     = 3'd4;
    wr_pck_size = SW'(70);
    rd_ready    = 1'b1;
    #1 check("t5_ack_refused", wr_ack, 0);
    step();
    rd_ready = 1'b0;
    check("t5_next_page", rd_pageaddr, 301);
    #1 check("t5_ack_next_edge", wr_ack, 1);
    step();
    wr_valid = 1'b0;
    check("t5_full_again", queue_full, 8'h10);
    drain(17);

    // Reset mid-operation: five queued, one presented.
    for (int i = 0; i < 6; i++) begin
      write_desc(PW'(400 + i), 3'd3, SW'(80));
    end
    check("t6_presented", rd_valid, 1);
    check("t6_empty", queue_empty, 8'hF7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid, 0);
    check("t6_rst_idle", idle, 1);
    check("t6_rst_empty", queue_empty, 8'hFF);
    check("t6_rst_full", queue_full, 8'h00);
    step();
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_valid_after_rst", rd_valid, 0);
    end
    rd_ready = 1'b0;
    write_desc(PW'(500), 3'd0, SW'(1));
    expect_desc(3'd0, PW'(500), SW'(1));
    step();
    drain(1);

    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/swc_prio_scheduler.md
SWC_PRIO_SCHEDULER -- requirements
Module: swc_prio_scheduler

Interface
REQ-001 The block SHALL have parameter g_num_prio, default 8, meaning the number of priority queues (prio width = 3).
REQ-002 The block SHALL have parameter g_queue_depth, default 16, meaning the descriptors per queue (power of 2).
REQ-003 The block SHALL have parameter g_page_addr_width, default 10, meaning the page address width.
REQ-004 The block SHALL have parameter g_max_pck_size_width, default 14, meaning the packet size width.
REQ-005 Port clk_i SHALL be an input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 Port rst_n_i SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-007 Port wr_valid_i SHALL be an input, 1 bit: a descriptor is offered.
REQ-008 Port wr_pageaddr_i SHALL be an input, g_page_addr_width bits: the first page of the packet.
REQ-009 Port wr_prio_i SHALL be an input, 3 bits: the target queue.
REQ-010 Port wr_pck_size_i SHALL be an input, g_max_pck_size_width bits: the packet size.
REQ-011 Port wr_ack_o SHALL be an output, 1 bit: the descriptor is accepted on this edge.
REQ-012 Port rd_valid_o SHALL be an output, 1 bit: a scheduled descriptor is present.
REQ-013 Port rd_ready_i SHALL be an input, 1 bit: the read engine takes the descriptor.
REQ-014 Port rd_pageaddr_o SHALL be an output, g_page_addr_width bits: the scheduled page address.
REQ-015 Port rd_pck_size_o SHALL be an output, g_max_pck_size_width bits: the scheduled size.
REQ-016 Port rd_prio_o SHALL be an output, 3 bits: the queue the descriptor came from.
REQ-017 Port queue_empty_o SHALL be an output, g_num_prio bits: the per-queue empty flags.
REQ-018 Port queue_full_o SHALL be an output, g_num_prio bits: the per-queue full flags.
REQ-019 Port idle_o SHALL be an output, 1 bit: all queues are empty and rd_valid_o=0.

Function
REQ-020 wr_ack_o SHALL be combinational and equal wr_valid_i AND NOT queue_full_o[wr_prio_i].
- The descriptor is pushed on the same edge.
- Writes to a full queue SHALL NOT be acked.
- The writer holds the descriptor until it is acked.
- No data SHALL be lost or overwritten.
REQ-021 Each queue SHALL be a circular FIFO with read/write pointers of log2(g_queue_depth) bits, wrapping modulo depth.
- The count SHALL use log2(depth)+1 bits.
- full SHALL be count=depth; empty SHALL be count=0.
- Both flags SHALL be registered.
REQ-022 A push and a pop to the same queue on the same edge SHALL leave the count unchanged.
- Both pointers SHALL advance.
- When that queue is full, the push SHALL still be refused, because the full flag is evaluated before the pop.
REQ-023 Selection SHALL be strict priority over the registered empty flags: the highest-index non-empty queue wins.
- A descriptor written at edge N SHALL be selectable at edge N+1 at the earliest.
REQ-024 The output stage SHALL be a two-state FSM, with states IDLE and VALID.
REQ-025 IDLE -> VALID SHALL occur on an edge where any queue is non-empty.
- On that edge the winning head SHALL be loaded into rd_pageaddr_o, rd_pck_size_o and rd_prio_o, and popped.
- rd_valid_o SHALL be 1 in VALID.
REQ-026 In VALID, the outputs SHALL be held stable while rd_ready_i=0.
REQ-027 In VALID with rd_ready_i=1, the transfer SHALL complete on that edge.
- If any queue is non-empty, the next winner SHALL be loaded and popped on the same edge, and the FSM stays in VALID (back-to-back, no bubble).
- Otherwise the FSM SHALL go to IDLE, clear rd_valid_o, and hold the last data values.
REQ-028 Priority SHALL be re-evaluated only when loading; a higher-priority arrival SHALL NOT pre-empt a presented descriptor.
REQ-029 Latency from acked write into an empty block to rd_valid_o=1 SHALL be 2 edges.
REQ-030 Within one queue, the output order SHALL be FIFO.
REQ-031 wr_prio_i >= g_num_prio SHALL be treated as prio g_num_prio-1.

Reset
REQ-032 When rst_n_i=0, the block SHALL asynchronously reset all pointers and counts to 0 and the FSM to IDLE.
- rd_valid_o SHALL reset to 0.
- rd_pageaddr_o, rd_pck_size_o and rd_prio_o SHALL reset to 0.
- queue_empty_o SHALL reset to all ones and queue_full_o to all zeros; idle_o SHALL reset to 1.
REQ-033 FIFO storage contents SHALL NOT require reset.
REQ-034 Reset asserted mid-operation SHALL discard all queued and presented descriptors.
- No rd_valid_o SHALL appear after reset until a new write is acked.

Verification
REQ-035 The bench SHALL write pageaddr 0..9 at prio 7 (size 10), then 0..9 at prio 0 (size 20), with rd_ready_i=0, then set rd_ready_i=1.
- Required response: 20 consecutive transfers.
- The ten prio-7 descriptors come first (pageaddr 0..9, size 10), then the ten prio-0 descriptors (size 20).
- There are no bubbles, then idle_o=1.
REQ-036 The bench SHALL perform 17 writes to prio 2 with rd_ready_i=0.
- Required response: 16 writes are acked, queue_full_o=0x04, and the 17th has wr_ack_o=0 and is held.
- After one transfer, the 17th is acked.
REQ-037 The bench SHALL write one descriptor (page 5, prio 3, size 64) while the block is idle and rd_ready_i=1.
- Required response: rd_valid_o=1 exactly 2 edges after the acked edge, with rd_prio_o=3, rd_pageaddr_o=5, rd_pck_size_o=64.
- Valid lasts one cycle.
REQ-038 The bench SHALL present a prio-1 descriptor with rd_ready_i=0, write a prio-6 descriptor, then raise rd_ready_i.
- Required response: prio 1 is delivered first (no pre-emption), then prio 6.
REQ-039 The bench SHALL fill prio 4 to full and, on one edge, both pop prio 4 and write prio 4.
- Required response: the write is refused that edge and accepted the next edge; the FIFO order is preserved.
REQ-040 The bench SHALL assert rst_n_i for one cycle with 5 descriptors queued and one presented.
- Required response: rd_valid_o=0 and idle_o=1 immediately; nothing is delivered until new writes.
